fir_mac_seq: RTL
================

// Module: fir_mac_seq
// PURPOSE
//   Parametrised, time-multiplexed FIR filter: y[n] = sum_{k=0..NTAPS-1} coef[k]*x[n-k].
//   One shared multiplier-accumulator, NTAPS cycles per sample; valid/ready stream on input
//   and output, and a runtime-writable coefficient bank. Sits in the equaliser datapath.
// PARAMETERS
//   DATA_W  16  signed sample width (input and output)
//   COEF_W  16  signed coefficient width
//   NTAPS   16  number of taps, >= 2
//   FRAC_W  15  fractional bits of coef; result is shifted right by FRAC_W, FRAC_W >= 1
// PORTS
//   clk         in   1                     clock, all logic on rising edge
//   rst         in   1                     reset: synchronous, active-high
//   in_valid    in   1                     input sample valid
//   in_ready    out  1                     block can accept a sample
//   in_data     in   DATA_W                signed input sample x[n]
//   coef_we     in   1                     coefficient write strobe
//   coef_addr   in   $clog2(NTAPS)         tap index k
//   coef_wdata  in   COEF_W                signed coefficient value
//   coef_ready  out  1                     coefficient write is honoured this cycle
//   out_valid   out  1                     output sample valid
//   out_ready   in   1                     downstream accepts the output
//   out_data    out  DATA_W                signed result y[n]
//   sat_flag    out  1                     result of current out_data was clipped
// BEHAVIOUR
//   - Reset: state IDLE; delay line, coefs, accumulator, tap counter = 0;
//     in_ready = 1, coef_ready = 1, out_valid = 0, out_data = 0, sat_flag = 0.
//   - FSM IDLE -> MAC -> HOLD -> IDLE.
//     IDLE: in_ready = coef_ready = 1. in_valid & in_ready: x[0] <= in_data,
//       x[i] <= x[i-1], acc <= 0, tap <= 0, go to MAC.
//     MAC: one product coef[tap]*x[tap] added to acc per cycle, tap 0..NTAPS-1;
//       after tap NTAPS-1, latch rounded result into out_data, go to HOLD.
//     HOLD: out_valid = 1. out_data and sat_flag stay stable until out_ready.
//       out_valid & out_ready: go to IDLE.
//   - Latency: accept at cycle t -> out_valid at t+NTAPS+1. Max throughput is one
//     sample per NTAPS+2 cycles with out_ready tied high.
//   - in_ready = 0 outside IDLE. coef_ready = 0 outside IDLE.
//     coef_we with coef_ready = 0 is dropped with no effect.
//   - coef_we and an input accept in the same IDLE cycle: the write lands first,
//     so the new coef applies to that sample.
//   - Arithmetic: product is DATA_W+COEF_W bits, signed.
//     ACC_W = DATA_W+COEF_W+$clog2(NTAPS), so no accumulator overflow is possible.
//     Round half-up: r = (acc + 2**(FRAC_W-1)) >>> FRAC_W (arithmetic shift), then
//     reduce to DATA_W bits per CONFIGURATION.
//   - rst asserted in any state, including mid-MAC or HOLD: full return to reset
//     values next edge. The in-flight sample is discarded and coefs are cleared.
// CONFIGURATION
//   FIR_SAT_EN defined: r outside [-2**(DATA_W-1), 2**(DATA_W-1)-1] clamps to the
//     nearest limit; sat_flag = 1 with that out_data.
//   FIR_SAT_EN undefined: out_data = r[DATA_W-1:0] (two's-complement wrap);
//     sat_flag tied 0.
// STRUCTURE
//   - Package fir_pkg: typedef enum fir_state_e {IDLE, MAC, HOLD}; function acc_w()
//     returning ACC_W; round/saturate function sat_round(acc, FRAC_W, DATA_W).
//   - Sub-module fir_mac_unit: registered signed multiply-accumulate
//     (clr, en, a, b -> acc). The top holds the FSM, delay line, coef bank and output
//     register.
// TESTING (defaults, coef Q1.15)
//   - Impulse: coef[k]=k*256, x = 16384 then zeros -> y = 128*k for k=0..15,
//     each out_valid exactly 17 cycles after its accept.
//   - Identity: coef[0]=32767, rest 0, x=1000 -> y=1000 (round half-up of 999.97).
//   - Backpressure: out_ready low 5 cycles in HOLD -> out_data stable, in_ready = 0,
//     coef_we dropped; release -> IDLE next cycle.
//   - Saturation: all coef=32767, x=32767 x16 -> FIR_SAT_EN: y=32767, sat_flag=1;
//     without: wrapped low 16 bits, sat_flag=0.
//   - Reset mid-MAC at tap 7 -> next cycle in_ready=1, out_valid=0; the next impulse
//     yields all-zero outputs (coefs cleared).
//   - Coef write plus accept in the same cycle: coef[0]=16384, x=2 -> y=1.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and fixed-point helpers for fir_mac_seq.
// Rounding is half-up; saturation helpers are used when FIR_SAT_EN is set.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } fir_state_e;

  localparam int RND_W = 64;

  function automatic int acc_w(
    input int data_w,
    input int coef_w,
    input int ntaps
  );
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  function automatic logic signed [RND_W-1:0] round_hu(
    input logic signed [RND_W-1:0] acc,
    input int                      frac_w
  );
    logic signed [RND_W-1:0] half;
    half = 64'sd1 <<< (frac_w - 1);
    return (acc + half) >>> frac_w;
  endfunction

  function automatic logic signed [RND_W-1:0] lim_hi(
    input int data_w
  );
    return (64'sd1 <<< (data_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [RND_W-1:0] lim_lo(
    input int data_w
  );
    return -(64'sd1 <<< (data_w - 1));
  endfunction

  function automatic logic signed [RND_W-1:0] sat_round(
    input logic signed [RND_W-1:0] acc,
    input int                      frac_w,
    input int                      data_w
  );
    logic signed [RND_W-1:0] r;
    r = round_hu(acc, frac_w);
    if (r > lim_hi(data_w)) return lim_hi(data_w);
    if (r < lim_lo(data_w)) return lim_lo(data_w);
    return r;
  endfunction

  function automatic logic sat_hit(
    input logic signed [RND_W-1:0] acc,
    input int                      frac_w,
    input int                      data_w
  );
    logic signed [RND_W-1:0] r;
    r = round_hu(acc, frac_w);
    return (r > lim_hi(data_w)) || (r < lim_lo(data_w));
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: registered signed multiply-accumulate.
// acc presents the running sum including the current product.
import fir_pkg::*;

module fir_mac_unit #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 36
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
  assign acc      = acc_q + prod_ext;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR, one shared MAC, NTAPS cycles per sample.
// Define FIR_SAT_EN to clamp out-of-range results instead of wrapping.
import fir_pkg::*;

module fir_mac_seq #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 16,
  parameter int FRAC_W = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     coef_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     sat_flag
);

  localparam int TAP_W = $clog2(NTAPS);
  localparam int ACC_W = acc_w(DATA_W, COEF_W, NTAPS);

  fir_state_e state_q;
  fir_state_e state_d;

  logic [TAP_W-1:0] tap_q;
  logic [TAP_W-1:0] tap_d;

  logic signed [DATA_W-1:0] x_q    [NTAPS];
  logic signed [DATA_W-1:0] x_d    [NTAPS];
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [COEF_W-1:0] coef_d [NTAPS];

  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic              sat_q;
  logic              sat_d;

  logic accept;
  logic coef_wr;
  logic last_tap;
  logic mac_en;
  logic mac_clr;

  logic signed [ACC_W-1:0] acc_sum;
  logic signed [RND_W-1:0] acc_ext;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = MAC;
      MAC:  if (last_tap) state_d = HOLD;
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready   = 1'b0;
    coef_ready = 1'b0;
    out_valid  = 1'b0;
    mac_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready   = 1'b1;
        coef_ready = 1'b1;
      end
      MAC:  mac_en    = 1'b1;
      HOLD: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign coef_wr  = coef_we & coef_ready;
  assign mac_clr  = accept;
  assign last_tap = mac_en && (tap_q == TAP_W'(NTAPS - 1));

  // Coef write lands in the accept cycle, so it applies to that sample.
  always_comb begin
    x_d    = x_q;
    coef_d = coef_q;
    tap_d  = tap_q;
    if (coef_wr) begin
      coef_d[coef_addr] = coef_wdata;
    end
    if (accept) begin
      x_d[0] = in_data;
      for (int i = 1; i < NTAPS; i++) begin
        x_d[i] = x_q[i-1];
      end
      tap_d = '0;
    end else if (mac_en && !last_tap) begin
      tap_d = tap_q + TAP_W'(1);
    end
  end

  // Last tap: acc_sum already holds the complete sum of products.
  always_comb begin
    acc_ext    = {{(RND_W-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
    out_data_d = out_data_q;
    sat_d      = sat_q;
    if (last_tap) begin
`ifdef FIR_SAT_EN
      out_data_d = DATA_W'(sat_round(acc_ext, FRAC_W, DATA_W));
      sat_d      = sat_hit(acc_ext, FRAC_W, DATA_W);
`else
      out_data_d = DATA_W'(round_hu(acc_ext, FRAC_W));
      sat_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q      <= '0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      tap_q      <= tap_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
      x_q        <= x_d;
      coef_q     <= coef_d;
    end
  end

  fir_mac_unit #(
    .A_W   (DATA_W),
    .B_W   (COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (x_q[tap_q]),
    .b   (coef_q[tap_q]),
    .acc (acc_sum)
  );

  assign out_data = out_data_q;
  assign sat_flag = sat_q;

endmodule
